alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 in_valid  input  1  operand/opcode bundle presented.
REQ-005 in_ready  output  1  block can accept a bundle this cycle.
REQ-006 operand_a  input  WIDTH  operand A, unsigned.
REQ-007 operand_b  input  WIDTH  operand B, unsigned.
REQ-008 opcode  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul, 110 not A, 111 xnor.
REQ-009 out_valid  output  1  result/zero hold a completed operation.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 result  output  2*WIDTH  registered result.
REQ-012 zero  output  1  registered; 1 when result == 0.

Function
REQ-013 FSM states IDLE, MUL, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 Accept occurs on a cycle with in_valid && in_ready; operands and opcode captured in that cycle, later input changes ignored.
REQ-015 Non-mul accept: IDLE -> DONE; result and zero valid on the next cycle (latency 1).
REQ-016 Mul accept: IDLE -> MUL; iterative shift-add, one multiplier bit per cycle, exactly WIDTH cycles in MUL, then DONE (out_valid WIDTH+1 cycles after accept).
REQ-017 DONE: result and zero held stable while out_ready = 0; on out_valid && out_ready -> IDLE; in_ready rises on the following cycle (no same-cycle re-accept).
REQ-018 Add: result[WIDTH:0] = a + b, carry in bit WIDTH; upper bits zero.
REQ-019 Sub: result[WIDTH-1:0] = (a - b) mod 2^WIDTH; result[WIDTH] = 1 when a < b (borrow); upper bits zero.
REQ-020 And/or/xor/xnor/not: bitwise on WIDTH bits into result[WIDTH-1:0]; result[2*WIDTH-1:WIDTH] = 0 (not and xnor do not set upper bits).
REQ-021 Mul: result = a * b, full 2*WIDTH-bit unsigned product, no truncation.
REQ-022 zero computed on the full 2*WIDTH-bit result, updated together with result.
REQ-023 In MUL, out_valid = 0 and in_valid ignored; result output unspecified until DONE.
REQ-024 out_ready asserted outside DONE has no effect.

Reset
REQ-025 rst_n low: immediately state IDLE, in_ready = 1, out_valid = 0, result = 0, zero = 1, multiplier counter/accumulator cleared.
REQ-026 Reset asserted mid-MUL or in DONE aborts the operation; no out_valid for it after reset release.
REQ-027 First accept possible on the first rising edge with rst_n high.

Verification (WIDTH = 8)
REQ-028 Add a=200, b=100, out_ready=1 -> one cycle later out_valid=1, result=0x012C, zero=0.
REQ-029 Sub a=5, b=7 -> result=0x01FE; sub a=9, b=9 -> result=0x0000, zero=1.
REQ-030 Mul a=255, b=255 -> out_valid exactly 9 cycles after accept, result=0xFE01; in_ready=0 throughout.
REQ-031 Not a=0x0F -> result=0x00F0; xnor a=0xAA, b=0xAA -> result=0x00FF.
REQ-032 Backpressure: xor 0x3C,0x0F with out_ready=0 for 5 cycles -> result=0x0033 stable, in_ready=0; out_ready=1 -> IDLE next cycle, new bundle accepted.
REQ-033 Reset pulse 4 cycles into mul 12*13 -> out_valid stays 0, result=0, zero=1; following add 1+1 -> result=0x0002.

Source files
------------

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative shift-add multiply.
// Result and zero flag are registered and held until the consumer accepts them.
module alu_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  input  logic [2:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   result_q, result_d;
  logic            zero_q, zero_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [W:0]      sum_w;
  logic [W:0]      diff_w;
  logic [W-1:0]    logic_w;
  logic [RW-1:0]   alu_res;
  logic [RW-1:0]   mac_sum;

  // Single-cycle datapath; the extra bit of diff_w is the borrow
  always_comb begin
    sum_w  = {1'b0, operand_a} + {1'b0, operand_b};
    diff_w = {1'b0, operand_a} - {1'b0, operand_b};
    case (opcode)
      OP_AND:  logic_w = operand_a & operand_b;
      OP_OR:   logic_w = operand_a | operand_b;
      OP_XOR:  logic_w = operand_a ^ operand_b;
      OP_NOT:  logic_w = ~operand_a;
      OP_XNOR: logic_w = ~(operand_a ^ operand_b);
      default: logic_w = '0;
    endcase
    case (opcode)
      OP_ADD:  alu_res = {{(W-1){1'b0}}, sum_w};
      OP_SUB:  alu_res = {{(W-1){1'b0}}, diff_w};
      default: alu_res = {{W{1'b0}}, logic_w};
    endcase
  end

  // One multiplier bit per cycle
  assign mac_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          if (opcode == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = {{W{1'b0}}, operand_a};
            mplier_d = operand_b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end
      end
      S_MUL: begin
        acc_d    = mac_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d  = S_DONE;
          result_d = mac_sum;
          zero_d   = (mac_sum == '0);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH = 8) with hand-computed expectations.
module tb_alu_pipe;

  localparam int unsigned WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   operand_a;
  logic [WIDTH-1:0]   operand_b;
  logic [2:0]         opcode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               zero;

  int tests = 0;
  int fails = 0;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one bundle for exactly one accept cycle
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    operand_a = a;
    operand_b = b;
    opcode    = op;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    operand_a = 8'h00;
    operand_b = 8'h00;
  endtask

  // Non-mul op with out_ready high: check DONE cycle, then return to IDLE
  task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [15:0] exp_res, input logic exp_zero);
    out_ready = 1'b1;
    issue(a, b, op);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_res"},   32'(result),    32'(exp_res));
    check({tag, "_zero"},  32'(zero),      32'(exp_zero));
    check({tag, "_rdy"},   32'(in_ready),  32'd0);
    tick();
    check({tag, "_idle"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    operand_a = '0;
    operand_b = '0;
    opcode    = 3'b000;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_rdy",   32'(in_ready),  32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_res",   32'(result),    32'd0);
    check("rst_zero",  32'(zero),      32'd1);
    rst_n = 1'b1;

    single("add",     8'd200, 8'd100, 3'b000, 16'h012C, 1'b0);
    single("add_cy",  8'hFF,  8'h01,  3'b000, 16'h0100, 1'b0);
    single("sub_brw", 8'd5,   8'd7,   3'b001, 16'h01FE, 1'b0);
    single("sub_eq",  8'd9,   8'd9,   3'b001, 16'h0000, 1'b1);
    single("and",     8'hF0,  8'h3C,  3'b010, 16'h0030, 1'b0);
    single("or",      8'hF0,  8'h0F,  3'b011, 16'h00FF, 1'b0);
    single("not",     8'h0F,  8'h55,  3'b110, 16'h00F0, 1'b0);
    single("xnor",    8'hAA,  8'hAA,  3'b111, 16'h00FF, 1'b0);
    single("xor_z",   8'h5A,  8'h5A,  3'b100, 16'h0000, 1'b1);

    // Mul 255*255: 8 cycles busy, a competing bundle on the inputs is ignored
    out_ready = 1'b1;
    issue(8'd255, 8'd255, 3'b101);
    in_valid  = 1'b1;
    opcode    = 3'b000;
    operand_a = 8'd1;
    operand_b = 8'd1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("mul_busy_valid%0d", k), 32'(out_valid), 32'd0);
      check($sformatf("mul_busy_rdy%0d", k),   32'(in_ready),  32'd0);
      if (k == 8) in_valid = 1'b0;
      tick();
    end
    check("mul_valid", 32'(out_valid), 32'd1);
    check("mul_res",   32'(result),    32'hFE01);
    check("mul_zero",  32'(zero),      32'd0);
    tick();
    check("mul_idle",  32'(in_ready),  32'd1);

    // Further products, including a zero product
    issue(8'd12, 8'd13, 3'b101);
    for (int k = 1; k <= 8; k++) tick();
    check("mul2_valid", 32'(out_valid), 32'd1);
    check("mul2_res",   32'(result),    32'h009C);
    tick();
    issue(8'd0, 8'd77, 3'b101);
    for (int k = 1; k <= 8; k++) tick();
    check("mul0_res",  32'(result), 32'h0000);
    check("mul0_zero", 32'(zero),   32'd1);
    tick();

    // Backpressure: result held, then a bundle waiting during the release is not taken early
    out_ready = 1'b0;
    issue(8'h3C, 8'h0F, 3'b100);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("bp_res%0d", k),   32'(result),    32'h0033);
      check($sformatf("bp_rdy%0d", k),   32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    operand_a = 8'd1;
    operand_b = 8'd2;
    opcode    = 3'b000;
    in_valid  = 1'b1;
    tick();
    check("bp_idle_rdy",   32'(in_ready),  32'd1);
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_res",   32'(result),    32'h0003);
    tick();

    // Reset 4 cycles into a multiply aborts it
    out_ready = 1'b0;
    issue(8'd12, 8'd13, 3'b101);
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    #1;
    check("ar_rdy",   32'(in_ready),  32'd1);
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_res",   32'(result),    32'd0);
    check("ar_zero",  32'(zero),      32'd1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("ar_quiet%0d", k), 32'(out_valid), 32'd0);
      tick();
    end
    check("ar_res_hold", 32'(result), 32'd0);
    single("post_rst_add", 8'd1, 8'd1, 3'b000, 16'h0002, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
